// File: rtl/adder48_accum_seq.sv
// Streaming accumulate/subtract sequencer around an external WIDTH-bit adder; one result per packet.
// Latency: the result is valid the cycle after the last (or MAX_BEATS-th) beat is accepted.
// Backpressure: in_ready drops while a result is held; the result holds until out_ready.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   in_valid/in_ready               operand beat handshake
//   in_data, in_sub, in_last        operand, subtract select, end-of-packet marker
//   add_a, add_b, add_c0            drive the external adder (A = accumulator, B = operand)
//   add_s, add_c48                  sum and carry-out returned by the adder (same cycle)
//   out_valid/out_ready             result handshake
//   out_sum, out_ccnt, out_ovf,     packet sum, saturating carry/borrow count,
//   out_trunc                       sticky signed overflow, forced-termination flag
module adder48_accum_seq #(
  parameter int WIDTH     = 48,
  parameter int CNT_W     = 8,
  parameter int MAX_BEATS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:1]   in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic [WIDTH:1]   add_a,
  output logic [WIDTH:1]   add_b,
  output logic             add_c0,
  input  logic [WIDTH:1]   add_s,
  input  logic             add_c48,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:1]   out_sum,
  output logic [CNT_W-1:0] out_ccnt,
  output logic             out_ovf,
  output logic             out_trunc
);

  // Beat counter must be able to hold MAX_BEATS itself.
  localparam int BC_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:1]   acc;
  logic [BC_W-1:0]  beat_cnt;
  logic [CNT_W-1:0] ccnt, ccnt_nxt;
  logic             ovf, ovf_nxt;
  logic             trunc, trunc_nxt;
  logic             accept;
  logic             at_max;
  logic             end_pkt;
  logic             cc_event;

  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;

  // First beat of a packet starts from zero, so a leading subtract yields 0 - in_data.
  assign add_a  = (state == IDLE) ? '0 : acc;
  // Subtraction as A + ~B + 1.
  assign add_b  = in_sub ? ~in_data : in_data;
  assign add_c0 = in_sub;

  // beat_cnt counts beats already taken, so this beat is the MAX_BEATS-th one.
  // beat_cnt is zero in IDLE, which also covers MAX_BEATS == 1 there.
  assign at_max  = (beat_cnt == BC_W'(MAX_BEATS - 1));
  assign end_pkt = in_last || at_max;

  // A carry out on add means unsigned wrap; on subtract, a missing carry means borrow.
  assign cc_event  = in_sub ? !add_c48 : add_c48;
  assign ccnt_nxt  = (cc_event && (ccnt != '1)) ? ccnt + CNT_W'(1) : ccnt;
  // Signed overflow: operands of equal sign produce a result of the other sign.
  assign ovf_nxt   = ovf || ((add_a[WIDTH] == add_b[WIDTH]) && (add_s[WIDTH] != add_a[WIDTH]));
  assign trunc_nxt = trunc || (!in_last && at_max);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = end_pkt ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept && end_pkt) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      beat_cnt  <= '0;
      ccnt      <= '0;
      ovf       <= 1'b0;
      trunc     <= 1'b0;
      out_sum   <= '0;
      out_ccnt  <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else if (accept) begin
      acc      <= add_s;
      beat_cnt <= beat_cnt + BC_W'(1);
      ccnt     <= ccnt_nxt;
      ovf      <= ovf_nxt;
      trunc    <= trunc_nxt;
      // Results are captured only on entry to HOLD, including the final beat's effect.
      if (end_pkt) begin
        out_sum   <= add_s;
        out_ccnt  <= ccnt_nxt;
        out_ovf   <= ovf_nxt;
        out_trunc <= trunc_nxt;
      end
    end else if ((state == HOLD) && out_ready) begin
      // Working state is cleared as the result leaves; out_* keep their last values.
      acc      <= '0;
      beat_cnt <= '0;
      ccnt     <= '0;
      ovf      <= 1'b0;
      trunc    <= 1'b0;
    end
  end

endmodule
